mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 208 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready request and
// response handshake, serving RV32I-style byte/half/word loads and stores.
// Each request waits a fixed number of cycles before its response is
// presented and held until the requester consumes it.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INI = 4'(WAIT_CYCLES - 1);
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        handshake;
    logic        commit;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wdata;
    logic [29:0] word_idx;
    logic [IDX_W-1:0] idx;
    logic [31:0] mem_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        oob;
    logic        err_fmt;
    logic        err_d;
    logic [31:0] load_val;
    logic [31:0] rdata_d;
    logic [3:0]  be_d;
    logic [31:0] wlane_d;
    logic        mem_we;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign handshake = req_valid && req_ready_q;

    // The transaction is decoded from the live inputs when it commits straight
    // out of IDLE (zero wait), otherwise from the captured request.
    assign cur_we    = (state_q == IDLE) ? req_we     : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    assign cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

    assign commit = (NO_WAIT && (state_q == IDLE) && handshake) ||
                    ((state_q == WAIT) && (cnt_q == 4'd0));

    // Decode the pending access: range/alignment/encoding errors, load result, store lanes
    always_comb begin
        word_idx = cur_addr[31:2];
        idx      = cur_addr[IDX_W+1:2];
        oob      = ({2'b00, word_idx} >= DEPTH_U);
        mem_word = mem[idx];
        byte_sel = mem_word[{cur_addr[1:0], 3'b000} +: 8];
        half_sel = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];

        err_fmt = 1'b1;
        case (cur_f3)
            3'b000:  err_fmt = 1'b0;
            3'b001:  err_fmt = cur_addr[0];
            3'b010:  err_fmt = |cur_addr[1:0];
            3'b100:  err_fmt = cur_we;
            3'b101:  err_fmt = cur_we | cur_addr[0];
            default: err_fmt = 1'b1;
        endcase
        err_d = oob | err_fmt;

        load_val = 32'd0;
        case (cur_f3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = mem_word;
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
        rdata_d = (cur_we || err_d) ? 32'd0 : load_val;

        be_d    = 4'b0000;
        wlane_d = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << cur_addr[1:0];
                wlane_d = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be_d    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wlane_d = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                be_d    = 4'b1111;
                wlane_d = cur_wdata;
            end
            default: begin
                be_d    = 4'b0000;
                wlane_d = cur_wdata;
            end
        endcase

        mem_we = commit && cur_we && !err_d;
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        req_ready_q <= 1'b0;
                        if (NO_WAIT) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_d;
                            rsp_err_q   <= err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INI;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Capture the request fields on the accepting edge
    always_ff @(posedge clk) begin
        if (handshake) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
        end
    end

    // Storage write, lane-masked, once per committing store; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (be_d[l]) begin
                    mem[idx][8*l +: 8] <= wlane_d[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WCYC  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WCYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_funct3(req_funct3),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic we, logic [31:0] addr, logic [2:0] f3,
                                logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err);
        vec_t v;
        v.nm = nm; v.we = we; v.addr = addr; v.f3 = f3;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request at #1 after a posedge (state IDLE), junk on the request
    // bus while busy, check latency and response, then consume it.
    task automatic txn(vec_t v);
        int n;
        check({v.nm, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_wdata  = v.wdata;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                check({v.nm, " req_ready busy"}, {31'd0, req_ready}, 32'd0);
                req_we     = ~v.we;
                req_addr   = $urandom;
                req_funct3 = 3'($urandom);
                req_wdata  = $urandom;
            end
        end while (!rsp_valid && n < 20);
        check({v.nm, " latency"}, 32'(n), 32'(WCYC + 1));
        check({v.nm, " rdata"}, rsp_rdata, v.exp_rdata);
        check({v.nm, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check({v.nm, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
        check({v.nm, " req_ready back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec_t v;

        add("SW 10",      1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h0,        0);
        add("LW 10 a",    0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 0);
        add("SB 11",      1, 32'h11,   3'b000, 32'h000000A5, 32'h0,        0);
        add("LW 10 b",    0, 32'h10,   3'b010, 32'h0,        32'hDEADA5EF, 0);
        add("LB 11",      0, 32'h11,   3'b000, 32'h0,        32'hFFFFFFA5, 0);
        add("LBU 11",     0, 32'h11,   3'b100, 32'h0,        32'h000000A5, 0);
        add("SH 12",      1, 32'h12,   3'b001, 32'h00008001, 32'h0,        0);
        add("LH 12",      0, 32'h12,   3'b001, 32'h0,        32'hFFFF8001, 0);
        add("LHU 12",     0, 32'h12,   3'b101, 32'h0,        32'h00008001, 0);
        add("LW 10 c",    0, 32'h10,   3'b010, 32'h0,        32'h8001A5EF, 0);
        add("LW 13 mis",  0, 32'h13,   3'b010, 32'h0,        32'h0,        1);
        add("SH 11 mis",  1, 32'h11,   3'b001, 32'h0000FFFF, 32'h0,        1);
        add("LW oob",     0, 32'h1000, 3'b010, 32'h0,        32'h0,        1);
        add("LW 10 d",    0, 32'h10,   3'b010, 32'h0,        32'h8001A5EF, 0);
        add("LD f3=3",    0, 32'h10,   3'b011, 32'h0,        32'h0,        1);
        add("ST f3=3",    1, 32'h10,   3'b011, 32'h0,        32'h0,        1);
        add("ST f3=6",    1, 32'h10,   3'b110, 32'h0,        32'h0,        1);
        add("SW oob",     1, 32'h1000, 3'b010, 32'h11111111, 32'h0,        1);
        add("LW 10 e",    0, 32'h10,   3'b010, 32'h0,        32'h8001A5EF, 0);
        add("LH 10",      0, 32'h10,   3'b001, 32'h0,        32'hFFFFA5EF, 0);
        add("LB 13",      0, 32'h13,   3'b000, 32'h0,        32'hFFFFFF80, 0);
        add("LBU 12",     0, 32'h12,   3'b100, 32'h0,        32'h00000001, 0);
        add("LHU 11 mis", 0, 32'h11,   3'b101, 32'h0,        32'h0,        1);
        add("SW last",    1, 32'hFFC,  3'b010, 32'h0BADF00D, 32'h0,        0);
        add("LW last",    0, 32'hFFC,  3'b010, 32'h0,        32'h0BADF00D, 0);
        add("SW 20",      1, 32'h20,   3'b010, 32'hCAFEF00D, 32'h0,        0);
        add("LW 20",      0, 32'h20,   3'b010, 32'h0,        32'hCAFEF00D, 0);

        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_funct3 = 3'b0; req_wdata = 32'h0; rsp_ready = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err",   {31'd0, rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < vecs.size(); i++) txn(vecs[i]);

        // Response held under backpressure with next request already waiting
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                req_addr = 32'h10; req_funct3 = 3'b100;
            end
        end while (!rsp_valid && n < 20);
        check("hold latency", 32'(n), 32'(WCYC + 1));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold rdata", rsp_rdata, 32'h8001A5EF);
            check("hold err", {31'd0, rsp_err}, 32'd0);
            check("hold req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("consume rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("consume req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("next handshake", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("next latency", 32'(n), 32'(WCYC + 1));
        check("next LBU rdata", rsp_rdata, 32'h000000EF);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset in WAIT abandons the store; rdata still holds the last load value
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010;
        req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst pre req_ready", {31'd0, req_ready}, 32'd0);
        check("rst pre rdata held", rsp_rdata, 32'h000000EF);
        #2 rst_n = 1'b0;
        #1;
        check("midrst req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst rsp_rdata", rsp_rdata, 32'd0);
        check("midrst rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("postrst no rsp", {31'd0, rsp_valid}, 32'd0);
        end
        v.nm = "LW 20 after rst"; v.we = 0; v.addr = 32'h20; v.f3 = 3'b010;
        v.wdata = 32'h0; v.exp_rdata = 32'hCAFEF00D; v.exp_err = 0;
        txn(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
